// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// owner_t tags which port performed the most recent memory access.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W   = 8;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_WAIT = 4;
  localparam int WAIT_CNT_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Host starvation counter: counts consecutive cycles the host has been refused,
// saturating at MAX_WAIT; sat tells the arbiter to hand the next slot to the host.
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [WAIT_CNT_W-1:0] cnt,
  output logic                  sat
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  // Clear wins over increment so a granted host always restarts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core/host) arbiter onto a single-port data memory with a
// combinational grant, core priority and a host anti-starvation override.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Handshake: a requester holds req/we/addr/wdata stable until it sees gnt
  // high at a rising edge; that edge performs exactly one access. Reads return
  // rdata with a one-cycle rvalid pulse on the following cycle.

  logic                  core_win;
  logic                  host_win;
  logic                  wait_sat;
  logic [WAIT_CNT_W-1:0] wait_cnt;

  logic                  core_rvalid_q, core_rvalid_d;
  logic                  host_rvalid_q, host_rvalid_d;
  logic [DATA_W-1:0]     core_rdata_q,  core_rdata_d;
  logic [DATA_W-1:0]     host_rdata_q,  host_rdata_d;
  owner_t                last_owner_q,  last_owner_d;

  // Reset gates the grant so nothing reaches the memory while RST_N is low.
  always_comb begin
    host_win = RST_N && host_req && (!core_req || wait_sat);
    core_win = RST_N && core_req && !host_win;
  end

  assign core_gnt = core_win;
  assign host_gnt = host_win;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk   (CLK),
    .rst_n (RST_N),
    .inc   (host_req && !host_win),
    .clr   (host_win || !host_req),
    .cnt   (wait_cnt),
    .sat   (wait_sat)
  );

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (core_win) begin
      mem_en    = 1'b1;
      mem_we    = core_we;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
    end else if (host_win) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  always_comb begin
    core_rvalid_d = core_win && !core_we;
    host_rvalid_d = host_win && !host_we;
    core_rdata_d  = core_rvalid_d ? mem_rdata : core_rdata_q;
    host_rdata_d  = host_rvalid_d ? mem_rdata : host_rdata_q;
    last_owner_d  = last_owner_q;
    if (core_win) begin
      last_owner_d = OWN_CORE;
    end else if (host_win) begin
      last_owner_d = OWN_HOST;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
      last_owner_q  <= OWN_NONE;
    end else begin
      core_rvalid_q <= core_rvalid_d;
      host_rvalid_q <= host_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      host_rdata_q  <= host_rdata_d;
      last_owner_q  <= last_owner_d;
    end
  end

  assign core_rvalid = core_rvalid_q;
  assign host_rvalid = host_rvalid_q;
  assign core_rdata  = core_rdata_q;
  assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, with a
// transaction-level reference model feeding a per-cycle expected-response queue.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int MAXW  = 4;
  localparam int EXP_W = 44;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          core_req = 1'b0, core_we = 1'b0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          host_req = 1'b0, host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          core_gnt, core_rvalid, host_gnt, host_rvalid;
  logic [DW-1:0] core_rdata, host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MAXW)) dut (
    .CLK(clk), .RST_N(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment memory: combinational read, write at the clock edge.
  logic [DW-1:0] tb_mem [256];
  assign mem_rdata = tb_mem[mem_addr];
  initial begin
    forever begin
      @(posedge clk);
      if (mem_en && mem_we) tb_mem[mem_addr] = mem_wdata;
    end
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] model_mem [256];
  int            host_lost = 0;
  bit            m_crv = 0, m_hrv = 0;
  logic [DW-1:0] m_crd = '0, m_hrd = '0;
  logic [1:0]    m_own = 2'd0;

  bit            c_pend = 0, c_we = 0, h_pend = 0, h_we = 0;
  logic [AW-1:0] c_addr = '0, h_addr = '0;
  logic [DW-1:0] c_wdata = '0, h_wdata = '0;

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  function automatic logic [EXP_W-1:0] pack_resp(
    input logic cg, input logic hg, input logic en, input logic we,
    input logic [AW-1:0] a, input logic [DW-1:0] wd,
    input logic crv, input logic hrv, input logic [DW-1:0] crd,
    input logic [DW-1:0] hrd, input logic [3:0] wc, input logic [1:0] own);
    return {cg, hg, en, we, a, wd, crv, hrv, crd, hrd, wc, own};
  endfunction

  // Monitor: every cycle the DUT presents a response, compare it to the oldest expectation.
  initial begin
    logic [EXP_W-1:0] e, a;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = pack_resp(core_gnt, host_gnt, mem_en, mem_we, mem_addr, mem_wdata,
                      core_rvalid, host_rvalid, core_rdata, host_rdata,
                      dut.wait_cnt, dut.last_owner_q);
        n_cmp++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_resp t=%0t got gnt=%b%b en=%b we=%b a=%h wd=%h rv=%b%b crd=%h hrd=%h wc=%0d own=%0d need gnt=%b%b en=%b we=%b a=%h wd=%h rv=%b%b crd=%h hrd=%h wc=%0d own=%0d",
            $time, a[43], a[42], a[41], a[40], a[39:32], a[31:24], a[23], a[22],
            a[21:14], a[13:6], a[5:2], a[1:0],
            e[43], e[42], e[41], e[40], e[39:32], e[31:24], e[23], e[22],
            e[21:14], e[13:6], e[5:2], e[1:0]);
        end
      end
    end
  end

  // ---------------- driver / model step ----------------
  // One clock cycle: drive pending requests, predict the response from the
  // arbitration rules, then apply the edge's effects to the model.
  task automatic step(input bit rst_v, input bit rst_before_edge);
    bit cw, hw, en, we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    @(negedge clk);
    rst_n      = rst_v;
    core_req   = c_pend; core_we = c_we; core_addr = c_addr; core_wdata = c_wdata;
    host_req   = h_pend; host_we = h_we; host_addr = h_addr; host_wdata = h_wdata;
    #1;
    cw = 0; hw = 0; en = 0; we = 0; a = '0; wd = '0;
    if (rst_n) begin
      if (c_pend && h_pend) begin
        hw = (host_lost >= MAXW);
        cw = !hw;
      end else begin
        cw = c_pend;
        hw = h_pend;
      end
      if (cw) begin en = 1; we = c_we; a = c_addr; wd = c_wdata; end
      if (hw) begin en = 1; we = h_we; a = h_addr; wd = h_wdata; end
      exp_q.push_back(pack_resp(cw, hw, en, we, a, wd, m_crv, m_hrv, m_crd, m_hrd,
                                4'(host_lost), m_own));
    end else begin
      exp_q.push_back('0);
    end
    #3;
    if (rst_before_edge) rst_n = 1'b0;
    if (!rst_n) begin
      host_lost = 0; m_crv = 0; m_hrv = 0; m_crd = '0; m_hrd = '0; m_own = 2'd0;
    end else begin
      m_crv = cw && !c_we;
      m_hrv = hw && !h_we;
      if (m_crv) m_crd = model_mem[c_addr];
      if (m_hrv) m_hrd = model_mem[h_addr];
      if (cw && c_we) model_mem[c_addr] = c_wdata;
      if (hw && h_we) model_mem[h_addr] = h_wdata;
      if (cw) m_own = 2'(OWN_CORE);
      if (hw) m_own = 2'(OWN_HOST);
      if (h_pend && !hw) host_lost = (host_lost < MAXW) ? host_lost + 1 : MAXW;
      else host_lost = 0;
      if (cw) c_pend = 0;
      if (hw) h_pend = 0;
    end
  endtask

  task automatic core_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    c_pend = 1; c_we = we; c_addr = a; c_wdata = d;
  endtask

  task automatic host_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    h_pend = 1; h_we = we; h_addr = a; h_wdata = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    tb_mem[a] = d;
    model_mem[a] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom_range(0, 255)));
    preload(8'd60, 8'd240);
    preload(8'd0, 8'd85);
    preload(8'd1, 8'd5);

    // Reset held two cycles with both ports requesting.
    core_txn(0, 8'd60, 8'd0);
    host_txn(0, 8'd1, 8'd0);
    step(0, 0);
    step(0, 0);
    // Requests that existed only during reset are withdrawn: no grant after release.
    c_pend = 0; h_pend = 0;
    step(1, 0);

    // Core read of address 60.
    core_txn(0, 8'd60, 8'd0);
    step(1, 0);
    step(1, 0);

    // Host write then core read of the same address.
    host_txn(1, 8'd61, 8'd7);
    step(1, 0);
    core_txn(0, 8'd61, 8'd0);
    step(1, 0);
    step(1, 0);

    // Starvation: both request continuously.
    host_txn(0, 8'd61, 8'd0);
    for (int k = 0; k < 7; k++) begin
      if (!c_pend) core_txn(1, 8'(100 + k), 8'(k));
      step(1, 0);
    end
    c_pend = 0;
    step(1, 0);

    // Back-to-back host reads of addresses 0 and 1.
    host_txn(0, 8'd0, 8'd0);
    step(1, 0);
    host_txn(0, 8'd1, 8'd0);
    step(1, 0);
    step(1, 0);

    // Reset before the edge of a granted core read: no rvalid pulse.
    core_txn(0, 8'd60, 8'd0);
    step(1, 1);
    c_pend = 0;
    step(0, 0);
    step(1, 0);
    step(1, 0);

    // Random traffic over a small address window to provoke read-after-write.
    for (int n = 0; n < 400; n++) begin
      if (!c_pend && $urandom_range(0, 99) < 60)
        core_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      if (!h_pend && $urandom_range(0, 99) < 55)
        host_txn(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      if (n == 200) begin
        step(1, 1);
        step(0, 0);
      end else begin
        step(1, 0);
      end
    end

    // Drain outstanding requests within a bounded number of cycles.
    for (int n = 0; n < 20 && (c_pend || h_pend); n++) step(1, 0);
    n_cmp++;
    if (c_pend || h_pend) begin
      n_fail++;
      $display("FAIL drain got pending core=%0d host=%0d need none", c_pend, h_pend);
    end
    step(1, 0);
    step(1, 0);
    @(negedge clk);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_empty got %0d entries left need 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, data memory address width (256 locations).
REQ-002 Parameter DATA_W, default 8, data memory word width.
REQ-003 Parameter MAX_WAIT, default 4, consecutive host-losing cycles before forced host grant; legal range 1..15.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, declared as the first two ports:
  CLK  in  1  rising-edge clock.
  RST_N  in  1  asynchronous active-low reset.
REQ-005 The remaining ports SHALL be:
  core_req  in  1  core requests one memory access.
  core_we  in  1  1=write, 0=read.
  core_addr  in  ADDR_W  core address.
  core_wdata  in  DATA_W  core write data.
  core_gnt  out  1  core access performed this cycle.
  core_rvalid  out  1  core read data valid.
  core_rdata  out  DATA_W  core read data.
  host_req / host_we / host_addr / host_wdata  in  1/1/ADDR_W/DATA_W  host port, same meaning.
  host_gnt / host_rvalid / host_rdata  out  1/1/DATA_W  host port, same meaning.
  mem_en  out  1  memory access this cycle.
  mem_we  out  1  memory write strobe.
  mem_addr  out  ADDR_W  memory address.
  mem_wdata  out  DATA_W  memory write data.
  mem_rdata  in  DATA_W  memory read data, combinational from mem_addr.

Function
REQ-006 Requester SHALL hold req, we, addr, wdata stable until its gnt is sampled high; each gnt completes exactly one access.
REQ-007 core_gnt and host_gnt SHALL be combinational from req inputs and registered state; never both high; gnt high only when own req high.
REQ-008 Single requester active: it SHALL be granted in the same cycle.
REQ-009 Both active: core SHALL win unless wait_cnt == MAX_WAIT, in which case host SHALL win.
REQ-010 wait_cnt (4-bit reg) SHALL increment when host_req && !host_gnt, saturating at MAX_WAIT; SHALL clear when host_gnt or !host_req.
REQ-011 Granted cycle: mem_en=1, mem_we=winner we, mem_addr/mem_wdata=winner addr/wdata; no grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-012 Granted read: mem_rdata SHALL be registered at the grant edge into winner rdata; winner rvalid SHALL pulse high exactly one cycle later, for one cycle.
REQ-013 Granted write: no rvalid pulse; rdata SHALL hold its previous value.
REQ-014 rdata SHALL hold last read value while rvalid low; back-to-back reads to the same port SHALL produce rvalid in consecutive cycles.
REQ-015 Read and write to same address in consecutive grants SHALL return post-write data (memory ordering preserved by single port).
REQ-016 last_owner register (NONE/CORE/HOST) SHALL record the owner of the most recent grant; debug-only, no effect on arbitration.

Reset
REQ-017 While RST_N low: all gnt, rvalid, mem_en, mem_we = 0; rdata, mem_addr, mem_wdata = 0; wait_cnt = 0; last_owner = NONE.
REQ-018 Reset asserted mid-transaction SHALL drop pending rvalid immediately; no grant in first cycle after RST_N rises if req was sampled during reset only.
REQ-019 First rising CLK edge after RST_N deassert SHALL evaluate arbitration normally.

Structure
REQ-020 Package dmem_arb_pkg SHALL hold owner_t enum {OWN_NONE, OWN_CORE, OWN_HOST} and default ADDR_W/DATA_W/MAX_WAIT constants.
REQ-021 Starvation counter SHALL be one sub-module, arb_wait_counter (inputs inc, clr; output cnt, sat).
REQ-022 No other hierarchy; response registers inline.

Verification
REQ-023 Reset: RST_N low 2 cycles with both req high -> all outputs 0, wait_cnt 0.
REQ-024 Core read only: core_req=1, addr=60, mem[60]=240 -> core_gnt same cycle, next cycle core_rvalid=1, core_rdata=240.
REQ-025 Host write then core read: host writes 7 to addr 61, next cycle core reads 61 -> core_rdata=7.
REQ-026 Starvation: both req held continuously, MAX_WAIT=4 -> core granted cycles 0-3, host granted cycle 4, wait_cnt 0 cycle 5.
REQ-027 Reset mid-read: core read granted, RST_N low before next edge -> core_rvalid never pulses.
REQ-028 Back-to-back host reads addr 0,1 (mem 85,5) -> host_rvalid two consecutive cycles, host_rdata 85 then 5.
